// File: rtl/bht_update_predictor.sv
// Branch history table of 2-bit saturating counters: combinational direction lookup for the
// fetch PC, training from resolved branches, and a one-entry-per-cycle clear sweep on flush.
module bht_update_predictor #(
   parameter int unsigned NR_ENTRIES = 64,
   parameter int unsigned VLEN       = 64
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            debug_mode_i,
   input  logic [VLEN-1:0] vpc_i,
   input  logic            res_valid_i,
   input  logic [VLEN-1:0] res_pc_i,
   input  logic            res_is_branch_i,
   input  logic            res_taken_i,
   output logic            pred_valid_o,
   output logic            pred_taken_o,
   output logic            busy_o
);

   localparam int unsigned IDX_W = $clog2(NR_ENTRIES);
   localparam logic [IDX_W-1:0] PtrLast = IDX_W'(NR_ENTRIES - 1);
   localparam logic [IDX_W-1:0] PtrOne  = IDX_W'(1);

   typedef enum logic {StIdle, StFlush} state_e;

   state_e                         r_state;
   logic   [IDX_W-1:0]             r_ptr;
   logic   [NR_ENTRIES-1:0]        r_valid;
   logic   [NR_ENTRIES-1:0][1:0]   r_cnt;

   state_e                         w_state_next;
   logic   [IDX_W-1:0]             w_ptr_next;
   logic                           w_wr_en;
   logic   [IDX_W-1:0]             w_wr_idx;
   logic                           w_wr_valid;
   logic   [1:0]                   w_wr_cnt;
   logic   [IDX_W-1:0]             w_lkp_idx;
   logic   [IDX_W-1:0]             w_res_idx;
   logic   [1:0]                   w_res_cnt;
   logic                           w_upd;
   logic                           w_unused;

   // Bit 0 is dropped: compressed instructions are 2-byte aligned.
   assign w_lkp_idx = vpc_i[IDX_W:1];
   assign w_res_idx = res_pc_i[IDX_W:1];
   assign w_res_cnt = r_cnt[w_res_idx];
   assign w_unused  = ^{vpc_i[VLEN-1:IDX_W+1], vpc_i[0], res_pc_i[VLEN-1:IDX_W+1], res_pc_i[0]};

   assign busy_o       = (r_state == StFlush);
   assign w_upd        = res_valid_i & res_is_branch_i & ~debug_mode_i & ~flush_i & ~busy_o;
   assign pred_valid_o = r_valid[w_lkp_idx] & ~busy_o & ~flush_i;
   assign pred_taken_o = pred_valid_o & r_cnt[w_lkp_idx][1];

   always_comb begin
      w_state_next = r_state;
      w_ptr_next   = r_ptr;
      w_wr_en      = 1'b0;
      w_wr_idx     = r_ptr;
      w_wr_valid   = 1'b0;
      w_wr_cnt     = 2'b01;
      unique case (r_state)
         StIdle: begin
            if (flush_i) begin
               w_state_next = StFlush;
               w_ptr_next   = '0;
            end else if (w_upd) begin
               w_wr_en    = 1'b1;
               w_wr_idx   = w_res_idx;
               w_wr_valid = 1'b1;
               if (!r_valid[w_res_idx]) begin
                  w_wr_cnt = res_taken_i ? 2'b10 : 2'b01;
               end else if (res_taken_i) begin
                  w_wr_cnt = (w_res_cnt == 2'b11) ? 2'b11 : w_res_cnt + 2'b01;
               end else begin
                  w_wr_cnt = (w_res_cnt == 2'b00) ? 2'b00 : w_res_cnt - 2'b01;
               end
            end
         end
         StFlush: begin
            w_wr_en = 1'b1;
            if (flush_i) begin
               w_ptr_next = '0;
            end else if (r_ptr == PtrLast) begin
               w_state_next = StIdle;
               w_ptr_next   = '0;
            end else begin
               w_ptr_next = r_ptr + PtrOne;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= StIdle;
         r_ptr   <= '0;
         r_valid <= '0;
         for (int i = 0; i < NR_ENTRIES; i++) begin
            r_cnt[i] <= 2'b01;
         end
      end else begin
         r_state <= w_state_next;
         r_ptr   <= w_ptr_next;
         if (w_wr_en) begin
            r_valid[w_wr_idx] <= w_wr_valid;
            r_cnt[w_wr_idx]   <= w_wr_cnt;
         end
      end
   end

endmodule

// File: tb/tb_bht_update_predictor.sv
// Directed bench for bht_update_predictor: expected lookup results are queued when a lookup is
// driven and popped/compared once the combinational outputs settle.
module tb_bht_update_predictor;

   localparam int unsigned N    = 64;
   localparam int unsigned VLEN = 64;

   logic            clk_i = 1'b0;
   logic            rst_ni = 1'b0;
   logic            flush_i = 1'b0;
   logic            debug_mode_i = 1'b0;
   logic [VLEN-1:0] vpc_i = '0;
   logic            res_valid_i = 1'b0;
   logic [VLEN-1:0] res_pc_i = '0;
   logic            res_is_branch_i = 1'b0;
   logic            res_taken_i = 1'b0;
   logic            pred_valid_o;
   logic            pred_taken_o;
   logic            busy_o;

   bht_update_predictor #(
      .NR_ENTRIES (N),
      .VLEN       (VLEN)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .flush_i         (flush_i),
      .debug_mode_i    (debug_mode_i),
      .vpc_i           (vpc_i),
      .res_valid_i     (res_valid_i),
      .res_pc_i        (res_pc_i),
      .res_is_branch_i (res_is_branch_i),
      .res_taken_i     (res_taken_i),
      .pred_valid_o    (pred_valid_o),
      .pred_taken_o    (pred_taken_o),
      .busy_o          (busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      string tag;
      logic  v;
      logic  t;
      logic  b;
   } exp_t;

   exp_t sb[$];
   int   n_err = 0;
   int   n_chk = 0;

   localparam logic [VLEN-1:0] PcA  = 64'h8000_0010; // idx 8
   localparam logic [VLEN-1:0] PcC  = 64'h40;        // idx 32
   localparam logic [VLEN-1:0] PcD  = 64'h60;        // idx 48
   localparam logic [VLEN-1:0] PcE  = 64'h100;       // idx 0
   localparam logic [VLEN-1:0] PcE2 = 64'h180;       // aliases PcE
   localparam logic [VLEN-1:0] PcF  = 64'h20;        // idx 16

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_pop();
      exp_t e;
      n_chk++;
      if (sb.size() == 0) begin
         n_err++;
         $error("FAIL scoreboard_empty got=0 entries exp>=1");
         return;
      end
      e = sb.pop_front();
      assert (pred_valid_o === e.v) else begin
         n_err++;
         $error("FAIL %s pred_valid got=%b exp=%b", e.tag, pred_valid_o, e.v);
      end
      n_chk++;
      assert (pred_taken_o === e.t) else begin
         n_err++;
         $error("FAIL %s pred_taken got=%b exp=%b", e.tag, pred_taken_o, e.t);
      end
      n_chk++;
      assert (busy_o === e.b) else begin
         n_err++;
         $error("FAIL %s busy got=%b exp=%b", e.tag, busy_o, e.b);
      end
   endtask

   task automatic look(input string tag, input logic [VLEN-1:0] pc, input logic ev,
                       input logic et, input logic eb);
      exp_t e;
      vpc_i = pc;
      e.tag = tag;
      e.v   = ev;
      e.t   = et;
      e.b   = eb;
      sb.push_back(e);
      #1;
      chk_pop();
   endtask

   task automatic drive_upd(input logic [VLEN-1:0] pc, input logic tk, input logic br,
                            input logic dbg);
      res_valid_i     = 1'b1;
      res_pc_i        = pc;
      res_taken_i     = tk;
      res_is_branch_i = br;
      debug_mode_i    = dbg;
   endtask

   task automatic clr_upd();
      res_valid_i     = 1'b0;
      res_is_branch_i = 1'b0;
      res_taken_i     = 1'b0;
      debug_mode_i    = 1'b0;
   endtask

   task automatic upd(input logic [VLEN-1:0] pc, input logic tk, input logic br,
                      input logic dbg);
      drive_upd(pc, tk, br, dbg);
      step();
      clr_upd();
   endtask

   initial begin
      // Reset state, checked while reset is held and across every index afterwards
      #2;
      look("in_reset", PcA, 1'b0, 1'b0, 1'b0);
      step();
      step();
      rst_ni = 1'b1;
      for (int i = 0; i < N; i++) begin
         look($sformatf("rst_sweep%0d", i), VLEN'(2 * i), 1'b0, 1'b0, 1'b0);
         step();
      end

      // Basic training: 10, 11, 10, 01
      upd(PcA, 1'b1, 1'b1, 1'b0);
      look("first_taken", PcA, 1'b1, 1'b1, 1'b0);
      upd(PcA, 1'b1, 1'b1, 1'b0);
      look("second_taken", PcA, 1'b1, 1'b1, 1'b0);
      upd(PcA, 1'b0, 1'b1, 1'b0);
      look("nt_from_11", PcA, 1'b1, 1'b1, 1'b0);
      upd(PcA, 1'b0, 1'b1, 1'b0);
      look("nt_to_01", PcA, 1'b1, 1'b0, 1'b0);

      // No bypass: same-cycle lookup sees the old counter (01)
      drive_upd(PcA, 1'b1, 1'b1, 1'b0);
      look("no_bypass", PcA, 1'b1, 1'b0, 1'b0);
      step();
      clr_upd();
      look("after_bypass", PcA, 1'b1, 1'b1, 1'b0);

      // Saturation
      for (int i = 0; i < 5; i++) upd(PcC, 1'b1, 1'b1, 1'b0);
      upd(PcC, 1'b0, 1'b1, 1'b0);
      look("sat_hi_then_nt", PcC, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) upd(PcD, 1'b0, 1'b1, 1'b0);
      look("sat_lo", PcD, 1'b1, 1'b0, 1'b0);
      upd(PcD, 1'b1, 1'b1, 1'b0); // 00 -> 01 stays not-taken; 01 would have gone to 10
      look("sat_lo_is_00", PcD, 1'b1, 1'b0, 1'b0);

      // Aliasing
      upd(PcE, 1'b1, 1'b1, 1'b0);
      look("alias_read", PcE2, 1'b1, 1'b1, 1'b0);
      upd(PcE2, 1'b0, 1'b1, 1'b0);
      upd(PcE2, 1'b0, 1'b1, 1'b0);
      look("alias_back", PcE, 1'b1, 1'b0, 1'b0);

      // Filtering: non-branch and debug-mode updates are ignored (A holds counter 10)
      upd(PcF, 1'b1, 1'b0, 1'b0);
      look("nonbranch_new", PcF, 1'b0, 1'b0, 1'b0);
      upd(PcF, 1'b1, 1'b1, 1'b1);
      look("debug_new", PcF, 1'b0, 1'b0, 1'b0);
      upd(PcA, 1'b0, 1'b0, 1'b0);
      look("nonbranch_valid", PcA, 1'b1, 1'b1, 1'b0);
      upd(PcA, 1'b0, 1'b1, 1'b1);
      look("debug_valid", PcA, 1'b1, 1'b1, 1'b0);

      // Flush: update in flush cycle, mid-sweep and on the last sweep cycle are all lost
      flush_i = 1'b1;
      drive_upd(PcF, 1'b1, 1'b1, 1'b0);
      look("flush_cycle", PcA, 1'b0, 1'b0, 1'b0);
      step();
      flush_i = 1'b0;
      clr_upd();
      for (int i = 1; i <= N; i++) begin
         if (i == 20 || i == N) drive_upd(PcF, 1'b1, 1'b1, 1'b0);
         look($sformatf("sweep%0d", i), PcA, 1'b0, 1'b0, 1'b1);
         step();
         clr_upd();
      end
      look("sweep_done", PcA, 1'b0, 1'b0, 1'b0);
      look("cleared_C", PcC, 1'b0, 1'b0, 1'b0);
      look("cleared_D", PcD, 1'b0, 1'b0, 1'b0);
      look("cleared_E", PcE, 1'b0, 1'b0, 1'b0);
      look("dropped_F", PcF, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < N; i++) begin
         look($sformatf("post_flush%0d", i), VLEN'(2 * i), 1'b0, 1'b0, 1'b0);
         step();
      end
      upd(PcA, 1'b1, 1'b1, 1'b0);
      look("train_after_flush", PcA, 1'b1, 1'b1, 1'b0);

      // Restart at sweep cycle 30 extends busy by a full sweep
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      for (int i = 1; i < 30; i++) step();
      flush_i = 1'b1;
      look("restart_cycle", PcA, 1'b0, 1'b0, 1'b1);
      step();
      flush_i = 1'b0;
      for (int i = 1; i <= N; i++) begin
         look($sformatf("restart%0d", i), PcA, 1'b0, 1'b0, 1'b1);
         step();
      end
      look("restart_done", PcA, 1'b0, 1'b0, 1'b0);

      // Reset at sweep cycle 10 abandons the sweep with the table cleared
      upd(PcA, 1'b1, 1'b1, 1'b0);
      look("train_before_rst", PcA, 1'b1, 1'b1, 1'b0);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      for (int i = 1; i < 10; i++) step();
      look("pre_rst_busy", PcA, 1'b0, 1'b0, 1'b1);
      rst_ni = 1'b0;
      look("mid_sweep_rst", PcA, 1'b0, 1'b0, 1'b0);
      step();
      rst_ni = 1'b1;
      step();
      look("after_rst_A", PcA, 1'b0, 1'b0, 1'b0);
      upd(PcC, 1'b0, 1'b1, 1'b0);
      look("fresh_after_rst", PcC, 1'b1, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/bht_update_predictor.md
# bht_update_predictor

Conditional-branch direction predictor in the frontend, at the receiving end of the branch-resolution path. It consumes resolved-branch outcomes produced by the execute-stage branch logic and trains a table of 2-bit saturating counters. It also answers same-cycle direction lookups for the fetch PC. Table clearing on a frontend flush runs as a sequential sweep, one entry per cycle, because the table has a single write port.

## Interface

Parameters:
- NR_ENTRIES, 64, number of table entries; must be a power of 2, at least 4.
- VLEN, riscv::VLEN, virtual address width.
- IDX_W, $clog2(NR_ENTRIES), derived; not overridable.

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  start a table-clear sweep.
- debug_mode_i  in  1  core is in debug mode; suppresses training.
- vpc_i  in  VLEN  fetch PC to look up.
- res_valid_i  in  1  resolved-branch update valid. Driven from bp_resolve_t.valid.
- res_pc_i  in  VLEN  PC of the resolved instruction. Driven from bp_resolve_t.pc.
- res_is_branch_i  in  1  resolved instruction is a conditional branch. Driven from cf_type == Branch.
- res_taken_i  in  1  actual outcome. Driven from cf_type.taken.
- pred_valid_o  out  1  the table holds a trained entry for vpc_i.
- pred_taken_o  out  1  predicted direction.
- busy_o  out  1  flush sweep in progress.

## Operation

- Index: idx(pc) = pc[IDX_W:1]. Bit 0 is ignored; compressed instructions are 2-byte aligned. There are no tags, so aliasing is accepted.
- Each entry holds a valid bit and a 2-bit counter. Counter encoding: 00 strong-not-taken, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup is combinational from registered state:
  - pred_valid_o = valid[idx(vpc_i)] & ~busy_o & ~flush_i.
  - pred_taken_o = pred_valid_o & counter[idx(vpc_i)][1].
- Update condition: res_valid_i & res_is_branch_i & ~debug_mode_i & ~flush_i & ~busy_o. Updates not meeting this condition are dropped; they are not queued.
- Update on an invalid entry: set valid; counter := res_taken_i ? 10 : 01.
- Update on a valid entry: if res_taken_i, counter := counter + 1, saturating at 11. Otherwise counter := counter - 1, saturating at 00.
- Non-branch resolutions (JAL, JALR, returns) never touch the table.
- FSM states:
  - IDLE -> FLUSH when flush_i = 1; sweep pointer := 0.
  - FLUSH: clear valid[ptr] and set counter[ptr] := 01 each cycle; ptr := ptr + 1.
  - FLUSH -> IDLE after clearing ptr = NR_ENTRIES-1. The pointer wraps to 0.
  - flush_i = 1 while in FLUSH restarts the sweep: ptr := 0, state stays FLUSH.
- busy_o = (state == FLUSH).

## Timing

- Reset (asynchronous): all valid := 0, all counters := 01, state := IDLE, ptr := 0. Outputs during and after reset: pred_valid_o = 0, pred_taken_o = 0, busy_o = 0.
- Lookup latency: 0 cycles (combinational).
- Update latency: an update sampled at edge N is visible to a lookup in the cycle after edge N.
- Same-cycle update and lookup to the same index: there is no bypass; the lookup returns the old state.
- Flush timing: flush_i high in cycle t gives busy_o high in cycles t+1 through t+NR_ENTRIES, which is exactly NR_ENTRIES cycles. The table is fully clear and busy_o = 0 in cycle t+NR_ENTRIES+1.
- Predictions are invalid in cycle t and for the whole sweep.
- Simultaneous flush_i and update: flush wins and the update is dropped.
- Update arriving on the final sweep cycle: dropped, since busy_o is still 1.
- Reset asserted mid-sweep: the block is immediately in the reset state; the sweep is abandoned.

## Test plan

- Reset, then sweep vpc_i across all indices -> pred_valid_o = 0 and pred_taken_o = 0 everywhere.
- Single update: pc = 0x8000_0010, taken = 1 -> next cycle, lookup at 0x8000_0010 gives valid = 1, taken = 1 (counter 10). A second taken update gives counter 11. Two not-taken updates then give counter 01 and taken = 0.
- Saturation: 5 taken updates to one PC, then 1 not-taken update -> taken = 1 (counter 10). Separately, 5 not-taken updates leave the counter at 00.
- Aliasing and filtering:
  - Updates to 0x100 and 0x100 + 2·NR_ENTRIES share one entry.
  - An update with res_is_branch_i = 0 leaves the table unchanged.
  - An update with debug_mode_i = 1 leaves the table unchanged.
- Flush with NR_ENTRIES = 64: train 3 entries, pulse flush_i in cycle t -> busy_o is high for exactly 64 cycles and pred_valid_o = 0 throughout. After the sweep, all entries read invalid. An update injected in the flush cycle and one injected mid-sweep are both lost.
- Restart and reset mid-flush:
  - Re-pulse flush_i at sweep cycle 30 -> busy_o stays high for 64 more cycles.
  - Assert rst_ni low at sweep cycle 10 -> busy_o = 0 immediately, with the table cleared.
